ita_regfile_access_arbiter: RTL and testbench
=============================================

ITA_REGFILE_ACCESS_ARBITER -- requirements
Module: ita_regfile_access_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_WIDTH, 5, register-file address width
- DATA_WIDTH, 32, word width
- N_WREQ, 4, number of write requesters
- N_READ, 2, number of read ports
- STALL_MAX, 3, blocked-read cycles before starvation override
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- wreq_valid_i, in, N_WREQ, write request
- wreq_ready_o, out, N_WREQ, write grant
- wreq_addr_i, in, N_WREQ x ADDR_WIDTH, write address per requester
- wreq_data_i, in, N_WREQ x DATA_WIDTH, write data per requester
- rreq_valid_i, in, N_READ, read request
- rreq_ready_o, out, N_READ, read accept
- rreq_addr_i, in, N_READ x ADDR_WIDTH, read address
- rdata_valid_o, out, N_READ, register-file ReadData valid
- rf_we_o, out, 1, register-file write enable
- rf_waddr_o, out, ADDR_WIDTH, register-file write address
- rf_wdata_o, out, DATA_WIDTH, register-file write data
- rf_re_o, out, N_READ, register-file read enable
- rf_raddr_o, out, N_READ x ADDR_WIDTH, register-file read address
- stat_wr_cnt_o, out, 32, granted-write counter
- stat_rd_stall_cnt_o, out, 32, blocked-read-cycle counter
REQ-003 One clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 Write arbitration SHALL be round-robin: grant the lowest eligible index >= rr_ptr, else wrap to the lowest eligible index; rr_ptr <= (granted+1) mod N_WREQ on a grant, unchanged otherwise.
REQ-005 Eligible = wreq_valid_i[i] and address not masked by REQ-010; at most one wreq_ready_o bit SHALL be high per cycle.
REQ-006 Handshake: transfer on valid&&ready; requesters hold valid/addr/data until ready; ready is combinational, same cycle.
REQ-007 Granted cycle: rf_we_o=1, rf_waddr_o/rf_wdata_o = granted requester's fields; no grant: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
REQ-008 Read hazard: rreq_ready_o[r] = rreq_valid_i[r] && !(rf_we_o && rf_waddr_o==rreq_addr_i[r]); reads to other addresses are never blocked; all read ports are independent.
REQ-009 rf_re_o[r] = rreq_valid_i[r]&&rreq_ready_o[r]; rf_raddr_o[r] = rreq_addr_i[r] (combinational); rdata_valid_o[r] SHALL be rf_re_o[r] registered (1-cycle latency).
REQ-010 Per-port stall_cnt[r] (saturating at STALL_MAX): +1 on a blocked valid cycle, cleared on accept or when valid low; while stall_cnt[r]==STALL_MAX, writes addressed to rreq_addr_i[r] SHALL be ineligible, so the read is accepted that cycle.
REQ-011 Simultaneous events: a write and a read to different addresses in one cycle SHALL both proceed; several reads to one address SHALL be blocked and released together.
REQ-012 A requester withdrawing valid without ready is a protocol violation; the block SHALL simply re-arbitrate next cycle.

Reset
REQ-013 While rst=1: all ready outputs, rf_we_o, rf_re_o and rdata_valid_o SHALL be 0; rf_waddr_o/rf_wdata_o SHALL be 0.
REQ-014 On a clk edge with rst=1: rr_ptr=0, all stall_cnt=0, rdata_valid_o=0, statistics counters=0. Mid-operation reset SHALL drop in-flight handshakes with no write issued.

Configuration
REQ-015 Macro ITA_REGFILE_ARB_STATS_EN defined: stat_wr_cnt_o +1 per rf_we_o cycle; stat_rd_stall_cnt_o +1 per blocked read port-cycle (per port, summed); both saturate at 2^32-1.
REQ-016 Macro undefined: both statistics outputs tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-017 Bench SHALL cover:
- All 4 writers valid continuously, distinct addresses -> grants 0,1,2,3,0 on consecutive cycles, rf_we_o=1 each cycle.
- Writers 1 and 3 valid, rr_ptr=2 -> 3 granted, then 1.
- Writer0 writes addr 5 while read port0 requests addr 5 -> rreq_ready_o[0]=0; next cycle no write -> accepted, rdata_valid_o[0]=1 one cycle later.
- Writers hammer addr 7 every cycle, read port1 valid on addr 7 -> blocked 3 cycles, accepted on 4th with rf_we_o=0 or writing another address.
- Reset asserted mid-burst -> outputs 0 same cycle, rr_ptr=0 after; with STATS_EN, both counters read 0.

Source files
------------

// File: rtl/ita_regfile_access_arbiter.sv
// Round-robin write arbiter for a register file with read-after-write hazard blocking and read starvation override.
// Optional statistics counters are enabled by defining ITA_REGFILE_ARB_STATS_EN.
module ita_regfile_access_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int N_WREQ     = 4,
   parameter int N_READ     = 2,
   parameter int STALL_MAX  = 3
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_WREQ-1:0]                   wreq_valid_i,
   output logic [N_WREQ-1:0]                   wreq_ready_o,
   input  logic [N_WREQ-1:0][ADDR_WIDTH-1:0]   wreq_addr_i,
   input  logic [N_WREQ-1:0][DATA_WIDTH-1:0]   wreq_data_i,
   input  logic [N_READ-1:0]                   rreq_valid_i,
   output logic [N_READ-1:0]                   rreq_ready_o,
   input  logic [N_READ-1:0][ADDR_WIDTH-1:0]   rreq_addr_i,
   output logic [N_READ-1:0]                   rdata_valid_o,
   output logic                                rf_we_o,
   output logic [ADDR_WIDTH-1:0]               rf_waddr_o,
   output logic [DATA_WIDTH-1:0]               rf_wdata_o,
   output logic [N_READ-1:0]                   rf_re_o,
   output logic [N_READ-1:0][ADDR_WIDTH-1:0]   rf_raddr_o,
   output logic [31:0]                         stat_wr_cnt_o,
   output logic [31:0]                         stat_rd_stall_cnt_o
);

   localparam int PTR_W   = (N_WREQ > 1) ? $clog2(N_WREQ) : 1;
   localparam int STALL_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

   logic [PTR_W-1:0]                rr_ptr;
   logic [N_READ-1:0][STALL_W-1:0]  stall_cnt;
   logic [N_READ-1:0]               starved;
   logic [N_READ-1:0]               blocked;
   logic [N_READ-1:0]               rdata_valid_p1;
   logic [N_WREQ-1:0]               eligible;
   logic [PTR_W-1:0]                gnt_idx;
   logic                            gnt_found;

   // A starved read port vetoes every write aimed at its address this cycle.
   always_comb begin
      for (int r = 0; r < N_READ; r++)
         starved[r] = rreq_valid_i[r] && (stall_cnt[r] == STALL_W'(STALL_MAX));
      for (int i = 0; i < N_WREQ; i++) begin
         eligible[i] = wreq_valid_i[i] && !rst;
         for (int r = 0; r < N_READ; r++)
            if (starved[r] && (wreq_addr_i[i] == rreq_addr_i[r]))
               eligible[i] = 1'b0;
      end
   end

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < N_WREQ; i++)
         if (!gnt_found && eligible[i] && (i >= int'(rr_ptr))) begin
            gnt_found = 1'b1;
            gnt_idx   = PTR_W'(i);
         end
      for (int i = 0; i < N_WREQ; i++)
         if (!gnt_found && eligible[i]) begin
            gnt_found = 1'b1;
            gnt_idx   = PTR_W'(i);
         end
   end

   always_comb begin
      wreq_ready_o = '0;
      rf_we_o      = gnt_found;
      rf_waddr_o   = '0;
      rf_wdata_o   = '0;
      if (gnt_found) begin
         wreq_ready_o[gnt_idx] = 1'b1;
         rf_waddr_o            = wreq_addr_i[gnt_idx];
         rf_wdata_o            = wreq_data_i[gnt_idx];
      end
   end

   always_comb begin
      for (int r = 0; r < N_READ; r++) begin
         rreq_ready_o[r] = !rst && rreq_valid_i[r] && !(rf_we_o && (rf_waddr_o == rreq_addr_i[r]));
         blocked[r]      = rreq_valid_i[r] && !rreq_ready_o[r];
      end
   end

   assign rf_re_o       = rreq_valid_i & rreq_ready_o;
   assign rf_raddr_o    = rreq_addr_i;
   assign rdata_valid_o = rdata_valid_p1 & {N_READ{!rst}};

   // Stage p1: arbitration pointer, stall tracking and read-data valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr         <= '0;
         stall_cnt      <= '0;
         rdata_valid_p1 <= '0;
      end else begin
         if (gnt_found)
            rr_ptr <= (gnt_idx == PTR_W'(N_WREQ - 1)) ? '0 : gnt_idx + 1'b1;
         rdata_valid_p1 <= rf_re_o;
         for (int r = 0; r < N_READ; r++) begin
            if (!blocked[r])
               stall_cnt[r] <= '0;
            else if (stall_cnt[r] != STALL_W'(STALL_MAX))
               stall_cnt[r] <= stall_cnt[r] + 1'b1;
         end
      end
   end

`ifdef ITA_REGFILE_ARB_STATS_EN
   logic [31:0] wr_cnt;
   logic [31:0] stall_sum_cnt;
   logic [32:0] stall_sum;

   always_comb begin
      stall_sum = {1'b0, stall_sum_cnt};
      for (int r = 0; r < N_READ; r++)
         stall_sum = stall_sum + 33'(blocked[r]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt        <= '0;
         stall_sum_cnt <= '0;
      end else begin
         if (rf_we_o && (wr_cnt != '1))
            wr_cnt <= wr_cnt + 1'b1;
         stall_sum_cnt <= stall_sum[32] ? '1 : stall_sum[31:0];
      end
   end

   assign stat_wr_cnt_o       = wr_cnt;
   assign stat_rd_stall_cnt_o = stall_sum_cnt;
`else
   assign stat_wr_cnt_o       = '0;
   assign stat_rd_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ita_regfile_access_arbiter.sv
// Scoreboard bench for ita_regfile_access_arbiter: each driven cycle pushes its expected outputs, a negedge monitor pops and compares.
module tb_ita_regfile_access_arbiter;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [3:0]            wreq_valid = '0;
   logic [3:0]            wreq_ready;
   logic [3:0][4:0]       wreq_addr = '0;
   logic [3:0][31:0]      wreq_data = '0;
   logic [1:0]            rreq_valid = '0;
   logic [1:0]            rreq_ready;
   logic [1:0][4:0]       rreq_addr = '0;
   logic [1:0]            rdata_valid;
   logic                  rf_we;
   logic [4:0]            rf_waddr;
   logic [31:0]           rf_wdata;
   logic [1:0]            rf_re;
   logic [1:0][4:0]       rf_raddr;
   logic [31:0]           stat_wr_cnt;
   logic [31:0]           stat_rd_stall_cnt;

   ita_regfile_access_arbiter dut (
      .clk                 (clk),
      .rst                 (rst),
      .wreq_valid_i        (wreq_valid),
      .wreq_ready_o        (wreq_ready),
      .wreq_addr_i         (wreq_addr),
      .wreq_data_i         (wreq_data),
      .rreq_valid_i        (rreq_valid),
      .rreq_ready_o        (rreq_ready),
      .rreq_addr_i         (rreq_addr),
      .rdata_valid_o       (rdata_valid),
      .rf_we_o             (rf_we),
      .rf_waddr_o          (rf_waddr),
      .rf_wdata_o          (rf_wdata),
      .rf_re_o             (rf_re),
      .rf_raddr_o          (rf_raddr),
      .stat_wr_cnt_o       (stat_wr_cnt),
      .stat_rd_stall_cnt_o (stat_rd_stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [3:0]  wready;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [1:0]  rready;
      logic [1:0]  re;
      logic [9:0]  raddr;
      logic [1:0]  rdv;
      logic [31:0] swr;
      logic [31:0] sst;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] acc_w    = 0;
   logic [31:0] acc_s    = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dat(input int i, input logic [4:0] a);
      return 32'hC0DE_0000 | (32'(i) << 8) | 32'(a);
   endfunction

   function automatic logic [3:0][4:0] a4(input logic [4:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [1:0][4:0] r2(input logic [4:0] a0, a1);
      return {a1, a0};
   endfunction

   // Drive one cycle of stimulus and push what the outputs must look like during it.
   task automatic cyc(input string tag, input logic r, input logic [3:0] wv, input logic [3:0][4:0] wa,
                      input logic [1:0] rv, input logic [1:0][4:0] ra,
                      input logic [3:0] e_wr, input logic e_we, input logic [4:0] e_wa,
                      input logic [1:0] e_rr, input logic [1:0] e_rdv);
      exp_t e;
      int   g;
      @(posedge clk);
      #1;
      rst        = r;
      wreq_valid = wv;
      wreq_addr  = wa;
      for (int i = 0; i < 4; i++) wreq_data[i] = dat(i, wa[i]);
      rreq_valid = rv;
      rreq_addr  = ra;
      g = 0;
      for (int i = 0; i < 4; i++) if (e_wr[i]) g = i;
      e.tag    = tag;
      e.wready = e_wr;
      e.we     = e_we;
      e.waddr  = e_wa;
      e.wdata  = e_we ? dat(g, e_wa) : 32'd0;
      e.rready = e_rr;
      e.re     = rv & e_rr;
      e.raddr  = ra;
      e.rdv    = e_rdv;
`ifdef ITA_REGFILE_ARB_STATS_EN
      e.swr    = acc_w;
      e.sst    = acc_s;
`else
      e.swr    = 32'd0;
      e.sst    = 32'd0;
`endif
      if (r) begin
         acc_w = 0;
         acc_s = 0;
      end else begin
         acc_w = acc_w + 32'(e_we);
         acc_s = acc_s + 32'($countones(rv & ~e_rr));
      end
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check_eq({mon_e.tag, ".wready"}, 64'(wreq_ready), 64'(mon_e.wready));
         check_eq({mon_e.tag, ".we"},     64'(rf_we),      64'(mon_e.we));
         check_eq({mon_e.tag, ".waddr"},  64'(rf_waddr),   64'(mon_e.waddr));
         check_eq({mon_e.tag, ".wdata"},  64'(rf_wdata),   64'(mon_e.wdata));
         check_eq({mon_e.tag, ".rready"}, 64'(rreq_ready), 64'(mon_e.rready));
         check_eq({mon_e.tag, ".re"},     64'(rf_re),      64'(mon_e.re));
         check_eq({mon_e.tag, ".raddr"},  64'(rf_raddr),   64'(mon_e.raddr));
         check_eq({mon_e.tag, ".rdv"},    64'(rdata_valid), 64'(mon_e.rdv));
         check_eq({mon_e.tag, ".swr"},    64'(stat_wr_cnt), 64'(mon_e.swr));
         check_eq({mon_e.tag, ".sst"},    64'(stat_rd_stall_cnt), 64'(mon_e.sst));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      // Reset holds every output low even with all requests pending.
      cyc("rst",     1, 4'hF, a4(10,11,12,13), 2'b11, r2(20,21), 4'b0000, 0, 0,  2'b00, 2'b00);
      // Round robin across four continuous writers.
      cyc("rr0",     0, 4'hF, a4(10,11,12,13), 2'b00, r2(0,0),   4'b0001, 1, 10, 2'b00, 2'b00);
      cyc("rr1",     0, 4'hF, a4(10,11,12,13), 2'b00, r2(0,0),   4'b0010, 1, 11, 2'b00, 2'b00);
      cyc("rr2",     0, 4'hF, a4(10,11,12,13), 2'b00, r2(0,0),   4'b0100, 1, 12, 2'b00, 2'b00);
      cyc("rr3",     0, 4'hF, a4(10,11,12,13), 2'b00, r2(0,0),   4'b1000, 1, 13, 2'b00, 2'b00);
      cyc("rr4",     0, 4'hF, a4(10,11,12,13), 2'b00, r2(0,0),   4'b0001, 1, 10, 2'b00, 2'b00);
      // Move pointer to 2, then writers 1 and 3 compete.
      cyc("rr_set",  0, 4'b0010, a4(10,11,12,13), 2'b00, r2(0,0), 4'b0010, 1, 11, 2'b00, 2'b00);
      cyc("rr_w3",   0, 4'b1010, a4(10,11,12,13), 2'b00, r2(0,0), 4'b1000, 1, 13, 2'b00, 2'b00);
      cyc("rr_w1",   0, 4'b1010, a4(10,11,12,13), 2'b00, r2(0,0), 4'b0010, 1, 11, 2'b00, 2'b00);
      // Hazard on addr 5 for port 0; port 1 on another address proceeds.
      cyc("haz_blk", 0, 4'b0001, a4(5,0,0,0), 2'b11, r2(5,20),     4'b0001, 1, 5,  2'b10, 2'b00);
      cyc("haz_acc", 0, 4'b0000, a4(5,0,0,0), 2'b01, r2(5,20),     4'b0000, 0, 0,  2'b01, 2'b10);
      cyc("haz_rdv", 0, 4'b0000, a4(0,0,0,0), 2'b00, r2(0,0),      4'b0000, 0, 0,  2'b00, 2'b01);
      // All writers hammer addr 7; port 1 starves for three cycles then wins.
      cyc("hot1",    0, 4'hF, a4(7,7,7,7), 2'b10, r2(0,7),         4'b0010, 1, 7,  2'b00, 2'b00);
      cyc("hot2",    0, 4'hF, a4(7,7,7,7), 2'b10, r2(0,7),         4'b0100, 1, 7,  2'b00, 2'b00);
      cyc("hot3",    0, 4'hF, a4(7,7,7,7), 2'b10, r2(0,7),         4'b1000, 1, 7,  2'b00, 2'b00);
      cyc("hot4",    0, 4'hF, a4(7,7,7,7), 2'b10, r2(0,7),         4'b0000, 0, 0,  2'b10, 2'b00);
      cyc("hot5",    0, 4'hF, a4(7,7,7,7), 2'b00, r2(0,7),         4'b0001, 1, 7,  2'b00, 2'b10);
      // Reset in the middle of a burst.
      cyc("mb1",     0, 4'hF, a4(10,11,12,13), 2'b11, r2(20,21), 4'b0010, 1, 11, 2'b11, 2'b00);
      cyc("mb2",     1, 4'hF, a4(10,11,12,13), 2'b11, r2(20,21), 4'b0000, 0, 0,  2'b00, 2'b00);
      cyc("mb3",     0, 4'hF, a4(10,11,12,13), 2'b00, r2(20,21), 4'b0001, 1, 10, 2'b00, 2'b00);
      cyc("mb4",     0, 4'h0, a4(10,11,12,13), 2'b00, r2(20,21), 4'b0000, 0, 0,  2'b00, 2'b00);
      repeat (2) @(posedge clk);
      check_eq("drain", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
